mfb_frame_gen: RTL and testbench

MFB_FRAME_GEN -- requirements
Module: mfb_frame_gen

---
 rtl/mfb_frame_gen.sv | 147 ++++++++++++++
 tb/tb_mfb_frame_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mfb_frame_gen.sv
// mfb_frame_gen: MFB test-frame generator.
// Accepts a frame length command, clamps it to [FRAME_SIZE_MIN, FRAME_SIZE_MAX]
// and emits the frame as MFB words. Every frame starts at item 0 of a fresh
// word. Item i carries (SEED+i), where SEED is the low ITEM_WIDTH bits of the
// frame counter at command acceptance.
// Ports:
//   clk, reset          sole clock, synchronous active-high reset
//   cmd_len/vld/rdy     frame length command handshake
//   tx_data             REGIONS*RI items, item 0 in the LSBs
//   tx_sof/eof(_pos)    per-region frame delimiters and positions
//   tx_src_rdy/dst_rdy  word handshake
//   frame_cnt           frames fully transferred (wraps)

// Per-region word decode: one instance per MFB region.
module mfb_frame_gen_region #(
  parameter int R          = 0,
  parameter int RI         = 64,
  parameter int ITEM_WIDTH = 8,
  parameter int LW         = 10,
  parameter int SPW        = 3,
  parameter int EPW        = 6
) (
  input  logic                           active,
  input  logic                           first,
  input  logic                           last,
  input  logic [LW-1:0]                  rem,
  input  logic [ITEM_WIDTH-1:0]          base,
  output logic [RI-1:0][ITEM_WIDTH-1:0]  data,
  output logic                           sof,
  output logic [SPW-1:0]                 sof_pos,
  output logic                           eof,
  output logic [EPW-1:0]                 eof_pos
);
  localparam logic [31:0] OFF = 32'(R*RI);

  logic [31:0] rem32, last_idx;
  assign rem32    = 32'(rem);
  assign last_idx = rem32 - 32'd1;

  // Frames always start at block 0 of region 0.
  assign sof     = active & first & (R == 0);
  assign sof_pos = '0;
  assign eof     = active & last & (last_idx >= OFF) & (last_idx < OFF + 32'(RI));
  assign eof_pos = eof ? EPW'(last_idx - OFF) : '0;

  // base is the value of item 0 of this word; items past EOF are zeroed.
  for (genvar k = 0; k < RI; k++) begin : g_item
    assign data[k] = (active && (!last || (OFF + 32'(k)) < rem32)) ?
                     base + ITEM_WIDTH'(OFF + 32'(k)) : '0;
  end
endmodule

module mfb_frame_gen #(
  parameter  int REGIONS        = 4,
  parameter  int REGION_SIZE    = 8,
  parameter  int BLOCK_SIZE     = 8,
  parameter  int ITEM_WIDTH     = 8,
  parameter  int FRAME_SIZE_MIN = 60,
  parameter  int FRAME_SIZE_MAX = 512,
  localparam int RI  = REGION_SIZE*BLOCK_SIZE,
  localparam int WI  = REGIONS*RI,
  localparam int LW  = $clog2(FRAME_SIZE_MAX+1),
  localparam int SPW = (REGION_SIZE > 1) ? $clog2(REGION_SIZE) : 1,
  localparam int EPW = (RI > 1) ? $clog2(RI) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [LW-1:0]              cmd_len,
  input  logic                       cmd_vld,
  output logic                       cmd_rdy,
  output logic [WI*ITEM_WIDTH-1:0]   tx_data,
  output logic [REGIONS-1:0]         tx_sof,
  output logic [REGIONS-1:0]         tx_eof,
  output logic [REGIONS*SPW-1:0]     tx_sof_pos,
  output logic [REGIONS*EPW-1:0]     tx_eof_pos,
  output logic                       tx_src_rdy,
  input  logic                       tx_dst_rdy,
  output logic [31:0]                frame_cnt
);
  typedef enum logic {IDLE, SEND} state_t;

  state_t                state;
  logic [LW-1:0]         rem, len_clamp;
  logic [ITEM_WIDTH-1:0] base;
  logic                  first;
  logic                  send, last, xfer, frame_done, accept;
  logic [31:0]           cnt_nxt;

  assign send       = (state == SEND);
  assign last       = 32'(rem) <= 32'(WI);
  assign xfer       = send & tx_dst_rdy;
  assign frame_done = xfer & last;
  // During the last word a new command can ride the same edge (no bubble).
  assign cmd_rdy    = !reset && (!send || (last && tx_dst_rdy));
  assign accept     = cmd_vld & cmd_rdy;
  assign tx_src_rdy = send;
  // Seed uses the post-increment count so a back-to-back frame sees the
  // frame it follows as already counted.
  assign cnt_nxt    = frame_cnt + 32'(frame_done);

  always_comb begin
    len_clamp = cmd_len;
    if (32'(cmd_len) < 32'(FRAME_SIZE_MIN))      len_clamp = LW'(FRAME_SIZE_MIN);
    else if (32'(cmd_len) > 32'(FRAME_SIZE_MAX)) len_clamp = LW'(FRAME_SIZE_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rem       <= '0;
      base      <= '0;
      first     <= 1'b0;
      frame_cnt <= '0;
    end else begin
      frame_cnt <= cnt_nxt;
      if (accept) begin
        state <= SEND;
        rem   <= len_clamp;
        base  <= cnt_nxt[ITEM_WIDTH-1:0];
        first <= 1'b1;
      end else if (frame_done) begin
        state <= IDLE;
      end else if (xfer) begin
        rem   <= rem - LW'(WI);
        base  <= base + ITEM_WIDTH'(WI);
        first <= 1'b0;
      end
    end
  end

  for (genvar r = 0; r < REGIONS; r++) begin : g_region
    mfb_frame_gen_region #(
      .R(r), .RI(RI), .ITEM_WIDTH(ITEM_WIDTH), .LW(LW), .SPW(SPW), .EPW(EPW)
    ) u_region (
      .active  (send),
      .first   (first),
      .last    (last),
      .rem     (rem),
      .base    (base),
      .data    (tx_data[r*RI*ITEM_WIDTH +: RI*ITEM_WIDTH]),
      .sof     (tx_sof[r]),
      .sof_pos (tx_sof_pos[r*SPW +: SPW]),
      .eof     (tx_eof[r]),
      .eof_pos (tx_eof_pos[r*EPW +: EPW])
    );
  end
endmodule

// File: tb/tb_mfb_frame_gen.sv
// Directed and randomized-stall bench for mfb_frame_gen at default generics
// (WI=256 items/word, RI=64 items/region, 8-bit items).
module tb_mfb_frame_gen;
  localparam int WI = 256, RI = 64, N = 10000;

  logic          clk = 1'b0, reset = 1'b1;
  logic [9:0]    cmd_len = '0;
  logic          cmd_vld = 1'b0, cmd_rdy;
  logic [2047:0] tx_data;
  logic [3:0]    tx_sof, tx_eof;
  logic [11:0]   tx_sof_pos;
  logic [23:0]   tx_eof_pos;
  logic          tx_src_rdy, tx_dst_rdy = 1'b1;
  logic [31:0]   frame_cnt;
  int            checks = 0, errs = 0;

  always #5 clk = ~clk;

  mfb_frame_gen dut (
    .clk(clk), .reset(reset), .cmd_len(cmd_len), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .tx_data(tx_data), .tx_sof(tx_sof), .tx_eof(tx_eof), .tx_sof_pos(tx_sof_pos),
    .tx_eof_pos(tx_eof_pos), .tx_src_rdy(tx_src_rdy), .tx_dst_rdy(tx_dst_rdy),
    .frame_cnt(frame_cnt)
  );

  // Word whose items 0..n-1 are seed+first_item+i, rest zero.
  function automatic logic [2047:0] ramp(input int seed, input int first_item, input int n);
    logic [2047:0] d = '0;
    for (int i = 0; i < n; i++) d[i*8 +: 8] = 8'(seed + first_item + i);
    return d;
  endfunction

  function automatic int first_diff(input logic [2047:0] a, input logic [2047:0] b);
    for (int i = 0; i < WI; i++) if (a[i*8 +: 8] !== b[i*8 +: 8]) return i;
    return 0;
  endfunction

  function automatic int clamp(input int l);
    return (l < 60) ? 60 : (l > 512) ? 512 : l;
  endfunction

  task automatic model_word(input int len, input int seed, input int widx,
                            output logic [2047:0] d, output logic [3:0] s,
                            output logic [3:0] e, output logic [23:0] ep);
    int rem;
    rem = len - widx*WI;
    d  = ramp(seed, widx*WI, (rem < WI) ? rem : WI);
    s  = (widx == 0) ? 4'b0001 : 4'b0000;
    e  = '0;
    ep = '0;
    if (rem <= WI) begin
      e[(rem-1)/RI] = 1'b1;
      ep[((rem-1)/RI)*6 +: 6] = 6'((rem-1) % RI);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; cmd_vld = 1'b0; tx_dst_rdy = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  // Present a command until accepted; returns just after the accepting edge.
  task automatic issue(input int len);
    @(negedge clk); cmd_len = 10'(len); cmd_vld = 1'b1; #1;
    for (int n = 0; n < 50 && cmd_rdy !== 1'b1; n++) begin @(negedge clk); #1; end
    checks++;
    if (cmd_rdy !== 1'b1) begin errs++; $display("FAIL issue_timeout len %0d cmd_rdy %b", len, cmd_rdy); end
    @(posedge clk); #1; cmd_vld = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if (cmd_rdy !== 1'b0) begin errs++; $display("FAIL rst_cmd_rdy got %b exp 0", cmd_rdy); end
    checks++; if ({tx_src_rdy, tx_sof, tx_eof, tx_sof_pos, tx_eof_pos} !== '0) begin errs++;
      $display("FAIL rst_ctrl src %b sof %b eof %b spos %h epos %h exp all 0", tx_src_rdy, tx_sof, tx_eof, tx_sof_pos, tx_eof_pos); end
    checks++; if (tx_data !== '0) begin errs++; $display("FAIL rst_data item %0d got %h exp 0", first_diff(tx_data, '0), tx_data[first_diff(tx_data, '0)*8 +: 8]); end
    checks++; if (frame_cnt !== 32'd0) begin errs++; $display("FAIL rst_frame_cnt got %0d exp 0", frame_cnt); end
    reset = 1'b0; #1;
    checks++; if (cmd_rdy !== 1'b1) begin errs++; $display("FAIL rst_release_cmd_rdy got %b exp 1", cmd_rdy); end
  endtask

  task automatic test_min_frame();
    logic [2047:0] e;
    do_reset(); issue(60);
    @(negedge clk); #1;
    checks++; if ({tx_src_rdy, tx_sof, tx_eof} !== 9'b1_0001_0001) begin errs++; $display("FAIL min_flags src %b sof %b eof %b exp 1 0001 0001", tx_src_rdy, tx_sof, tx_eof); end
    checks++; if (tx_eof_pos !== 24'd59 || tx_sof_pos !== '0) begin errs++; $display("FAIL min_pos epos %h spos %h exp 00003b 000", tx_eof_pos, tx_sof_pos); end
    e = ramp(0, 0, 60);
    checks++; if (tx_data !== e) begin errs++; $display("FAIL min_data item %0d got %h exp %h", first_diff(tx_data, e), tx_data[first_diff(tx_data, e)*8 +: 8], e[first_diff(tx_data, e)*8 +: 8]); end
    @(negedge clk); #1;
    checks++; if (tx_src_rdy !== 1'b0 || frame_cnt !== 32'd1 || cmd_rdy !== 1'b1) begin errs++;
      $display("FAIL min_after src %b cnt %0d cmd_rdy %b exp 0 1 1", tx_src_rdy, frame_cnt, cmd_rdy); end
  endtask

  task automatic test_two_word();
    logic [2047:0] e;
    do_reset(); issue(257);
    @(negedge clk); #1;
    checks++; if ({tx_sof, tx_eof, cmd_rdy} !== 9'b0001_0000_0) begin errs++; $display("FAIL w2_word1 sof %b eof %b cmd_rdy %b exp 0001 0000 0", tx_sof, tx_eof, cmd_rdy); end
    e = ramp(0, 0, 256);
    checks++; if (tx_data !== e) begin errs++; $display("FAIL w2_data1 item %0d got %h exp %h", first_diff(tx_data, e), tx_data[first_diff(tx_data, e)*8 +: 8], e[first_diff(tx_data, e)*8 +: 8]); end
    @(negedge clk); #1;
    checks++; if ({tx_sof, tx_eof, cmd_rdy} !== 9'b0000_0001_1 || tx_eof_pos !== '0) begin errs++;
      $display("FAIL w2_word2 sof %b eof %b cmd_rdy %b epos %h exp 0000 0001 1 0", tx_sof, tx_eof, cmd_rdy, tx_eof_pos); end
    checks++; if (tx_data !== '0) begin errs++; $display("FAIL w2_data2 item %0d got %h exp 00", first_diff(tx_data, '0), tx_data[first_diff(tx_data, '0)*8 +: 8]); end
    @(negedge clk); #1;
    checks++; if (frame_cnt !== 32'd1) begin errs++; $display("FAIL w2_frame_cnt got %0d exp 1", frame_cnt); end
  endtask

  task automatic test_clamp();
    logic [2047:0] e;
    issue(10);
    @(negedge clk); #1;
    checks++; if (tx_eof !== 4'b0001 || tx_eof_pos !== 24'd59) begin errs++; $display("FAIL clamp_lo eof %b epos %h exp 0001 00003b", tx_eof, tx_eof_pos); end
    e = ramp(1, 0, 60);
    checks++; if (tx_data !== e) begin errs++; $display("FAIL clamp_lo_data item %0d got %h exp %h", first_diff(tx_data, e), tx_data[first_diff(tx_data, e)*8 +: 8], e[first_diff(tx_data, e)*8 +: 8]); end
    @(negedge clk); #1;
    checks++; if (frame_cnt !== 32'd2) begin errs++; $display("FAIL clamp_lo_cnt got %0d exp 2", frame_cnt); end
    issue(1000);
    @(negedge clk); #1;
    checks++; if (tx_sof !== 4'b0001 || tx_eof !== 4'b0000) begin errs++; $display("FAIL clamp_hi_word1 sof %b eof %b exp 0001 0000", tx_sof, tx_eof); end
    @(negedge clk); #1;
    checks++; if (tx_sof !== 4'b0000 || tx_eof !== 4'b1000 || tx_eof_pos !== 24'hFC0000) begin errs++;
      $display("FAIL clamp_hi_word2 sof %b eof %b epos %h exp 0000 1000 fc0000", tx_sof, tx_eof, tx_eof_pos); end
    e = ramp(2, 256, 256);
    checks++; if (tx_data !== e) begin errs++; $display("FAIL clamp_hi_data item %0d got %h exp %h", first_diff(tx_data, e), tx_data[first_diff(tx_data, e)*8 +: 8], e[first_diff(tx_data, e)*8 +: 8]); end
    @(negedge clk); #1;
    checks++; if (frame_cnt !== 32'd3) begin errs++; $display("FAIL clamp_hi_cnt got %0d exp 3", frame_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [2047:0] e;
    do_reset();
    @(negedge clk); cmd_len = 10'd256; cmd_vld = 1'b1;
    @(posedge clk); #1; cmd_len = 10'd300;
    @(negedge clk); #1;
    checks++; if ({tx_src_rdy, tx_sof, tx_eof, cmd_rdy} !== 10'b1_0001_1000_1 || tx_eof_pos !== 24'hFC0000) begin errs++;
      $display("FAIL b2b_first src %b sof %b eof %b cmd_rdy %b epos %h exp 1 0001 1000 1 fc0000", tx_src_rdy, tx_sof, tx_eof, cmd_rdy, tx_eof_pos); end
    @(posedge clk); #1; cmd_vld = 1'b0;
    @(negedge clk); #1;
    checks++; if ({tx_src_rdy, tx_sof, tx_eof, cmd_rdy} !== 10'b1_0001_0000_0) begin errs++;
      $display("FAIL b2b_no_bubble src %b sof %b eof %b cmd_rdy %b exp 1 0001 0000 0", tx_src_rdy, tx_sof, tx_eof, cmd_rdy); end
    checks++; if (tx_data[7:0] !== 8'h01 || frame_cnt !== 32'd1) begin errs++; $display("FAIL b2b_seed item0 %h cnt %0d exp 01 1", tx_data[7:0], frame_cnt); end
    @(negedge clk); #1;
    checks++; if (tx_eof !== 4'b0001 || tx_eof_pos !== 24'd43) begin errs++; $display("FAIL b2b_last eof %b epos %h exp 0001 00002b", tx_eof, tx_eof_pos); end
    e = ramp(1, 256, 44);
    checks++; if (tx_data !== e) begin errs++; $display("FAIL b2b_data item %0d got %h exp %h", first_diff(tx_data, e), tx_data[first_diff(tx_data, e)*8 +: 8], e[first_diff(tx_data, e)*8 +: 8]); end
    @(negedge clk); #1;
    checks++; if (tx_src_rdy !== 1'b0 || frame_cnt !== 32'd2) begin errs++; $display("FAIL b2b_end src %b cnt %0d exp 0 2", tx_src_rdy, frame_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [2047:0] e;
    do_reset(); issue(512);
    @(negedge clk); #1;
    checks++; if (tx_sof !== 4'b0001) begin errs++; $display("FAIL rmid_word1 sof %b exp 0001", tx_sof); end
    @(negedge clk); #1;
    checks++; if (tx_eof !== 4'b1000) begin errs++; $display("FAIL rmid_word2 eof %b exp 1000", tx_eof); end
    reset = 1'b1;
    @(negedge clk); #1;
    checks++; if ({tx_src_rdy, cmd_rdy, tx_sof, tx_eof, tx_sof_pos, tx_eof_pos} !== '0 || tx_data !== '0) begin errs++;
      $display("FAIL rmid_outputs src %b cmd_rdy %b sof %b eof %b epos %h exp all 0", tx_src_rdy, cmd_rdy, tx_sof, tx_eof, tx_eof_pos); end
    checks++; if (frame_cnt !== 32'd0) begin errs++; $display("FAIL rmid_cnt got %0d exp 0", frame_cnt); end
    reset = 1'b0; #1;
    checks++; if (cmd_rdy !== 1'b1) begin errs++; $display("FAIL rmid_cmd_rdy got %b exp 1", cmd_rdy); end
    issue(60);
    @(negedge clk); #1;
    e = ramp(0, 0, 60);
    checks++; if (tx_data !== e) begin errs++; $display("FAIL rmid_seed item %0d got %h exp %h", first_diff(tx_data, e), tx_data[first_diff(tx_data, e)*8 +: 8], e[first_diff(tx_data, e)*8 +: 8]); end
  endtask

  task automatic test_random_stall();
    logic [2047:0] ed;
    logic [3:0]    es, ee;
    logic [23:0]   ep;
    int  issued = 0, fcnt = 0, len = 0, seed = 0, widx = 0, cyc = 0, idx;
    bit  in_frame = 0, acc = 0, mlast, erdy;
    do_reset();
    while (fcnt < N && cyc < 60000) begin
      @(negedge clk); cyc++;
      if (acc) cmd_vld = 1'b0;
      if (!cmd_vld && issued < N && $urandom_range(0, 7) != 0) begin
        cmd_vld = 1'b1; cmd_len = 10'($urandom_range(1, 700));
      end
      tx_dst_rdy = ($urandom_range(0, 3) != 0);
      #1;
      mlast = in_frame && (len - widx*WI <= WI);
      erdy  = !in_frame || (mlast && tx_dst_rdy);
      checks++;
      if (tx_src_rdy !== in_frame || cmd_rdy !== erdy || frame_cnt !== 32'(fcnt)) begin errs++;
        $display("FAIL rand_ctrl cyc %0d src %b cmd_rdy %b cnt %0d exp %b %b %0d", cyc, tx_src_rdy, cmd_rdy, frame_cnt, in_frame, erdy, fcnt); end
      if (in_frame) begin
        // Expected word is fixed per (frame, word index): also covers stall stability.
        model_word(len, seed, widx, ed, es, ee, ep);
        checks++;
        if (tx_data !== ed || tx_sof !== es || tx_eof !== ee || tx_eof_pos !== ep || tx_sof_pos !== '0) begin
          errs++; idx = first_diff(tx_data, ed);
          $display("FAIL rand_word frame %0d word %0d sof %b eof %b epos %h item %0d=%h exp sof %b eof %b epos %h item=%h",
                   fcnt, widx, tx_sof, tx_eof, tx_eof_pos, idx, tx_data[idx*8 +: 8], es, ee, ep, ed[idx*8 +: 8]);
        end
      end
      if (in_frame && tx_dst_rdy) begin
        if (mlast) begin fcnt++; in_frame = 0; end
        else widx++;
      end
      acc = cmd_vld && erdy;
      if (acc) begin
        in_frame = 1; len = clamp(int'(cmd_len)); seed = fcnt % 256; widx = 0; issued++;
      end
    end
    checks++; if (cyc >= 60000) begin errs++; $display("FAIL rand_timeout frames %0d exp %0d", fcnt, N); end
    @(negedge clk); cmd_vld = 1'b0; tx_dst_rdy = 1'b1; #1;
    checks++; if (frame_cnt !== 32'(N) || tx_src_rdy !== 1'b0) begin errs++; $display("FAIL rand_final cnt %0d src %b exp %0d 0", frame_cnt, tx_src_rdy, N); end
  endtask

  initial begin
    test_reset();
    test_min_frame();
    test_two_word();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    test_random_stall();
    $display("%0d/%0d checks passed", checks - errs, checks);
    $finish;
  end
endmodule
